// File: rtl/mac_pkg.sv
// Shared widths and helpers for the MAC sharing arbiter.
package mac_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first set request at or after ptr, wrapping modulo N.
module rr_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic        found;
    int unsigned idx;

    always_comb begin
        any       = |req;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        // Winner index is valid even when en is low; only the grant is gated.
        if (en && any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one external MAC among NUM_REQ requesters with a registered response.
module mac_share_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = mac_pkg::DATA_W,
    parameter int unsigned ACC_W   = mac_pkg::ACC_W,
    parameter int unsigned ID_W    = clog2_safe(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*DATA_W-1:0]   req_c,
    output logic [DATA_W-1:0]           mac_a,
    output logic [DATA_W-1:0]           mac_b,
    output logic [DATA_W-1:0]           mac_c,
    input  logic [ACC_W-1:0]            mac_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [ACC_W-1:0]            rsp_data,
    output logic [CNT_W-1:0]            op_count
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_req;
    logic               can_issue;
    logic               fire;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [ACC_W-1:0]   rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // One-entry buffer: a pending response may leave on the same edge a new one loads.
    assign can_issue = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (rst_n && can_issue),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    always_comb begin
        req_ready   = grant;
        fire        = |(req_valid & grant);
        mac_a       = '0;
        mac_b       = '0;
        mac_c       = '0;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        op_count_d  = op_count_q;

        if (any_req) begin
            mac_a = req_a[grant_idx*DATA_W +: DATA_W];
            mac_b = req_b[grant_idx*DATA_W +: DATA_W];
            mac_c = req_c[grant_idx*DATA_W +: DATA_W];
        end

        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = mac_result;
            ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (op_count_q != '1) begin
                op_count_d = op_count_q + 1'b1;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one combinational MAC datapath (a*b + c; 16-bit operands, 32-bit result) among NUM_REQ requesters.
- Each requester presents operands with a valid/ready handshake. Grants are round-robin, at most one operation per cycle.
- The MAC result is registered together with the winning requester's ID and returned on a single valid/ready response channel.
- Sits between the compute clients and the MAC instance; the MAC itself is instantiated outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 16, operand width.
- ACC_W, 32, MAC result width.
- ID_W, $clog2(NUM_REQ), requester ID width.
- CNT_W, 16, width of the saturating operation counter.

Ports:
- clk  input  1  system clock. One clock; reset is synchronous and active-low.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_W  operand a, requester i at bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand b, same packing.
- req_c  input  NUM_REQ*DATA_W  addend c, same packing.
- mac_a  output  DATA_W  to MAC in_a.
- mac_b  output  DATA_W  to MAC in_b.
- mac_c  output  DATA_W  to MAC in_c.
- mac_result  input  ACC_W  from MAC mac_out (combinational).
- rsp_valid  output  1  response register holds data.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  requester index of the response.
- rsp_data  output  ACC_W  MAC result.
- op_count  output  CNT_W  accepted operations since reset; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a clk edge): rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, round-robin pointer=0. During reset req_ready=0.
- can_issue = !rsp_valid || rsp_ready. This gives one-entry output buffering with same-cycle drain and refill.
- Arbitration (combinational):
  - Search req_valid starting at pointer ptr, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - grant = winner one-hot when can_issue and any req_valid is set; otherwise grant = 0.
  - req_ready = grant. req_ready never depends on req_valid of non-winners.
- MAC drive: mac_a/b/c = the winner's operands whenever any req_valid is set, otherwise zero. They are driven combinationally in the same cycle as the grant.
- Transfer on requester i: req_valid[i] && req_ready[i] at the edge. At that edge:
  - rsp_data <= mac_result
  - rsp_id <= i
  - rsp_valid <= 1
  - ptr <= (i+1) mod NUM_REQ
  - op_count <= op_count+1, saturating.
- Latency: response is visible one cycle after the accepting edge. Throughput is one operation per cycle when rsp_ready is held high.
- Response drained with no new grant: rsp_valid && rsp_ready && no grant -> rsp_valid <= 0 and rsp_data/rsp_id hold.
- Backpressure: rsp_valid=1 and rsp_ready=0 -> all req_ready=0; rsp_data and rsp_id stay stable until accepted.
- Simultaneous drain and grant: the old response leaves and the new one loads at the same edge; no bubble.
- No requests: ptr holds. The pointer only advances on a transfer.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,2,3,0,... Every requester is served within NUM_REQ consecutive grants.
- Arithmetic: the block never alters the result. Signedness and overflow are defined by the MAC.
- Reset mid-operation: a pending response is discarded with no handshake, and ptr returns to 0.
- Requester protocol: once req_valid is asserted it must stay high with stable operands until accepted. The bench checks this as an assertion.

Decomposition:
- mac_pkg holds:
  - localparams DATA_W=16 and ACC_W=32
  - function clog2_safe (returns 1 for NUM_REQ<=2).
- Sub-module rr_arbiter (parameter N) contains the rotating priority search.
  - Inputs: req[N], ptr, en.
  - Outputs: grant one-hot, grant_idx, any.
- mac_share_arbiter contains the operand mux, response register, pointer and counter.

Test Plan:
1. Single request: reset, then req_valid=4'b0100 with a=3, b=5, c=7 and rsp_ready=1 -> req_ready[2]=1 the same cycle; the next cycle rsp_valid=1, rsp_id=2, rsp_data=22, op_count=1.
2. Round-robin: all four requests held valid with distinct operands, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with one response per cycle and matching a*b+c values.
3. Backpressure: response pending and rsp_ready=0 for 5 cycles -> req_ready=0 and rsp_data/rsp_id stable throughout. Raising rsp_ready then drains and refills in the same cycle with no bubble.
4. Pointer wrap: last grant to requester 3, then only req_valid[0] and req_valid[3] set -> requester 0 wins first, then requester 3.
5. Reset mid-stream: assert rst_n=0 for one edge while rsp_valid=1 -> rsp_valid=0, op_count=0, rsp_data=0; the next grant goes to the lowest-index valid requester.
6. Edge operands: a=0xFFFF, b=0xFFFF, c=0xFFFF -> rsp_data equals the MAC output bit-exact (golden model uses the same MAC). Force op_count=0xFFFE and issue 3 operations -> op_count saturates at 0xFFFF.
